// File: rtl/bitonic_sort_pipe.sv
// -----------------------------------------------------------------------------
// bitonic_sort_pipe
//   Fully pipelined bitonic sorting network for N = 2**LOG2_LEN elements.
//   One compare-exchange stage per register stage, S = L*(L+1)/2 stages.
//   Each vector carries its own sort direction and emits its first TOPK
//   sorted elements.
//
// Handshake (valid/ready):
//   A transfer happens on a rising clk edge when valid and ready are both high.
//   The pipeline stalls as a whole when the output holds a vector that
//   downstream refuses (stall = out_valid_o & ~out_ready_i). in_ready_o is the
//   combinational inverse of stall. During a stall every stage register holds.
//   When there is no stall, empty slots (bubbles) advance like data.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset; clears all stage state
//   in_valid_i   input vector valid
//   in_ready_o   block can accept a vector this cycle
//   sign_ctrl_i  1 = descending (largest at y_o[0]), 0 = ascending
//   x_i[N]       input elements
//   out_valid_o  y_o holds a sorted vector
//   out_ready_i  downstream accepts the vector
//   sign_ctrl_o  direction that travelled with the output vector
//   y_o[TOPK]    first TOPK sorted elements
//   idx_o[TOPK]  original input position of each output element
//                (present only when BITONIC_SORT_IDX_EN is defined)
//
// Optional feature macro: BITONIC_SORT_IDX_EN
//   Defined: indices travel with the data. On equal keys, the lower original
//   index goes to the lower output position in both directions.
//   Undefined: equal keys are never swapped, and no index logic exists.
// -----------------------------------------------------------------------------
module bitonic_sort_pipe #(
  parameter int DATAWIDTH = 8,
  parameter int LOG2_LEN  = 3,
  parameter int TOPK      = 1 << LOG2_LEN,
  parameter int SIGNED    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 sign_ctrl_i,
  input  logic [DATAWIDTH-1:0] x_i [1 << LOG2_LEN],
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 sign_ctrl_o,
  output logic [DATAWIDTH-1:0] y_o [TOPK]
`ifdef BITONIC_SORT_IDX_EN
  ,
  output logic [LOG2_LEN-1:0]  idx_o [TOPK]
`endif
);

  localparam int N = 1 << LOG2_LEN;
  localparam int S = LOG2_LEN * (LOG2_LEN + 1) / 2;

  if (LOG2_LEN < 1 || LOG2_LEN > 6) begin : g_bad_len
    $fatal(1, "bitonic_sort_pipe: LOG2_LEN must be in 1..6");
  end
  if (TOPK < 1 || TOPK > N) begin : g_bad_topk
    $fatal(1, "bitonic_sort_pipe: TOPK must be in 1..N");
  end

  // Maps a flat stage number onto the (p, q) of the bitonic schedule:
  // p = 1..L, and for each p, q runs p down to 1.
  function automatic int stage_pq(input int s, input bit want_q);
    int k;
    int res;
    k   = s;
    res = 1;
    for (int p = 1; p <= LOG2_LEN; p++) begin
      if (k >= 0 && k < p) res = want_q ? (p - k) : p;
      k = k - p;
    end
    return res;
  endfunction

  function automatic logic val_gt(input logic [DATAWIDTH-1:0] a,
                                  input logic [DATAWIDTH-1:0] b);
    if (SIGNED != 0) val_gt = $signed(a) > $signed(b);
    else             val_gt = a > b;
  endfunction

`ifdef BITONIC_SORT_IDX_EN
  // Total order used by the whole network for one vector: value first, then
  // index, with the index order flipped for descending vectors so that the
  // lower index lands at the lower output position in both directions.
  function automatic logic key_gt(input logic [DATAWIDTH-1:0] a,
                                  input logic [LOG2_LEN-1:0]  ia,
                                  input logic [DATAWIDTH-1:0] b,
                                  input logic [LOG2_LEN-1:0]  ib,
                                  input logic                 sg);
    if (a != b) key_gt = val_gt(a, b);
    else        key_gt = sg ? (ia < ib) : (ia > ib);
  endfunction
`endif

  logic stall;
  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall;

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int P    = stage_pq(s, 1'b0);
    localparam int Q    = stage_pq(s, 1'b1);
    localparam int HALF = 1 << (Q - 1);

    logic [DATAWIDTH-1:0] d_in [N];
    logic [DATAWIDTH-1:0] d_cx [N];
    logic [DATAWIDTH-1:0] d_q  [N];
    logic                 v_in, sg_in;
    logic                 v_q, sg_q;
`ifdef BITONIC_SORT_IDX_EN
    logic [LOG2_LEN-1:0]  i_in [N];
    logic [LOG2_LEN-1:0]  i_cx [N];
    logic [LOG2_LEN-1:0]  i_q  [N];
`endif

    if (s == 0) begin : g_src
      assign d_in  = x_i;
      assign v_in  = in_valid_i & in_ready_o;
      assign sg_in = sign_ctrl_i;
`ifdef BITONIC_SORT_IDX_EN
      for (genvar e = 0; e < N; e++) begin : g_idx
        assign i_in[e] = LOG2_LEN'(e);
      end
`endif
    end else begin : g_chain
      assign d_in  = g_stage[s-1].d_q;
      assign v_in  = g_stage[s-1].v_q;
      assign sg_in = g_stage[s-1].sg_q;
`ifdef BITONIC_SORT_IDX_EN
      assign i_in  = g_stage[s-1].i_q;
`endif
    end

    // Compare-exchange: lane i pairs with i + HALF; local direction is bit P
    // of the lower lane index, flipped for descending vectors.
    always_comb begin : cx
      int   i;
      int   j;
      logic desc;
      logic swp;
      i    = 0;
      j    = 0;
      desc = 1'b0;
      swp  = 1'b0;
      for (int e = 0; e < N; e++) begin
        d_cx[e] = d_in[e];
`ifdef BITONIC_SORT_IDX_EN
        i_cx[e] = i_in[e];
`endif
      end
      for (int k = 0; k < N / 2; k++) begin
        i    = (k / HALF) * 2 * HALF + (k % HALF);
        j    = i + HALF;
        desc = sg_in ^ ((i & (1 << P)) != 0);
`ifdef BITONIC_SORT_IDX_EN
        swp  = desc ? key_gt(d_in[j], i_in[j], d_in[i], i_in[i], sg_in)
                    : key_gt(d_in[i], i_in[i], d_in[j], i_in[j], sg_in);
`else
        swp  = desc ? val_gt(d_in[j], d_in[i]) : val_gt(d_in[i], d_in[j]);
`endif
        if (swp) begin
          d_cx[i] = d_in[j];
          d_cx[j] = d_in[i];
`ifdef BITONIC_SORT_IDX_EN
          i_cx[i] = i_in[j];
          i_cx[j] = i_in[i];
`endif
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v_q  <= 1'b0;
        sg_q <= 1'b0;
        for (int e = 0; e < N; e++) begin
          d_q[e] <= '0;
`ifdef BITONIC_SORT_IDX_EN
          i_q[e] <= '0;
`endif
        end
      end else if (!stall) begin
        v_q  <= v_in;
        sg_q <= sg_in;
        for (int e = 0; e < N; e++) begin
          d_q[e] <= d_cx[e];
`ifdef BITONIC_SORT_IDX_EN
          i_q[e] <= i_cx[e];
`endif
        end
      end
    end
  end

  assign out_valid_o = g_stage[S-1].v_q;
  assign sign_ctrl_o = g_stage[S-1].sg_q;

  for (genvar k = 0; k < TOPK; k++) begin : g_out
    assign y_o[k] = g_stage[S-1].d_q[k];
`ifdef BITONIC_SORT_IDX_EN
    assign idx_o[k] = g_stage[S-1].i_q[k];
`endif
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// -----------------------------------------------------------------------------
// tb_bitonic_sort_pipe
//   Directed bench for bitonic_sort_pipe. Three instances share clk/rst:
//     u_def : default parameters (8 x 8-bit, unsigned, TOPK = 8)
//     u_sgn : LOG2_LEN = 2, SIGNED = 1
//     u_top : TOPK = 2
//   Index outputs are checked when BITONIC_SORT_IDX_EN is defined.
// -----------------------------------------------------------------------------
module tb_bitonic_sort_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       iv0 = 1'b0, rdy0, sc0 = 1'b0, ov0, or0 = 1'b1, so0;
  logic [7:0] x0 [8];
  logic [7:0] y0 [8];
  logic       iv1 = 1'b0, rdy1, sc1 = 1'b0, ov1, or1 = 1'b1, so1;
  logic [7:0] x1 [4];
  logic [7:0] y1 [4];
  logic       iv2 = 1'b0, rdy2, sc2 = 1'b0, ov2, or2 = 1'b1, so2;
  logic [7:0] x2 [8];
  logic [7:0] y2 [2];
`ifdef BITONIC_SORT_IDX_EN
  logic [2:0] idx0 [8];
  logic [1:0] idx1 [4];
  logic [2:0] idx2 [2];
`endif

  bitonic_sort_pipe u_def (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv0), .in_ready_o(rdy0),
    .sign_ctrl_i(sc0), .x_i(x0), .out_valid_o(ov0), .out_ready_i(or0),
    .sign_ctrl_o(so0), .y_o(y0)
`ifdef BITONIC_SORT_IDX_EN
    , .idx_o(idx0)
`endif
  );

  bitonic_sort_pipe #(.LOG2_LEN(2), .TOPK(4), .SIGNED(1)) u_sgn (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(rdy1),
    .sign_ctrl_i(sc1), .x_i(x1), .out_valid_o(ov1), .out_ready_i(or1),
    .sign_ctrl_o(so1), .y_o(y1)
`ifdef BITONIC_SORT_IDX_EN
    , .idx_o(idx1)
`endif
  );

  bitonic_sort_pipe #(.TOPK(2)) u_top (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv2), .in_ready_o(rdy2),
    .sign_ctrl_i(sc2), .x_i(x2), .out_valid_o(ov2), .out_ready_i(or2),
    .sign_ctrl_o(so2), .y_o(y2)
`ifdef BITONIC_SORT_IDX_EN
    , .idx_o(idx2)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack8(input logic [7:0] v [8]);
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p[8*k +: 8] = v[k];
    return p;
  endfunction

  // Reference sort (bubble sort on values).
  function automatic logic [63:0] ref_sort(input logic [7:0] v [8], input logic desc);
    logic [7:0] a [8];
    logic [7:0] t;
    a = v;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return pack8(a);
  endfunction

  // Deterministic stream vectors; lanes 0/6 and 1/7 repeat to create ties.
  function automatic logic [7:0] vec_val(input int v, input int i);
    if (v == 5 && i == 3) return 8'hFF;
    if (v == 5 && i == 4) return 8'h00;
    return 8'((v * 53 + (i % 6) * 71 + 17) % 256);
  endfunction

  function automatic logic out_v(input int which);
    case (which)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one vector for one cycle (ready assumed high) and counts the
  // cycles until out_valid rises, bounded at 30.
  task automatic send_one(input int which, input logic [7:0] v [8], input logic s,
                          output int cyc);
    case (which)
      0: begin x0 = v; sc0 = s; iv0 = 1'b1; end
      1: begin for (int k = 0; k < 4; k++) x1[k] = v[k]; sc1 = s; iv1 = 1'b1; end
      default: begin x2 = v; sc2 = s; iv2 = 1'b1; end
    endcase
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    cyc = 1;
    while (out_v(which) !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Streams nv vectors into u_def; out_ready is low in cycles [st0, st0+stl).
  task automatic run_stream(input int nv, input int st0, input int stl, input int base,
                            output int first_c, output int last_c, output int got);
    int   sent;
    logic rdy_m;
    sent = 0; got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 80 && got < nv; c++) begin
      or0 = !(c >= st0 && c < st0 + stl);
      iv0 = (sent < nv);
      for (int i = 0; i < 8; i++) x0[i] = vec_val(base + sent, i);
      sc0 = 1'((base + sent) % 2);
      #1;
      rdy_m = !(ov0 && !or0);
      chk("in_ready", 96'(rdy0), 96'(rdy_m));
      if (ov0 === 1'b1) begin
        chk("sb_head", 96'({so0, pack8(y0)}),
            (exp_q.size() > 0) ? 96'(exp_q[0]) : {96{1'bx}});
        if (or0) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got++;
          if (first_c < 0) first_c = c;
          last_c = c;
        end
      end
      if (iv0 && rdy_m) begin
        exp_q.push_back({sc0, ref_sort(x0, sc0)});
        sent++;
      end
      @(posedge clk); #1;
    end
    iv0 = 1'b0;
    or0 = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] xa [8];
  logic [7:0] xs [8];
  logic [7:0] xt [8];
  logic [2:0] ei [8];
  int cyc, fc, lc, got, seen, n;

  initial begin
    xa = '{8'd3, 8'd7, 8'd1, 8'd0, 8'd255, 8'd9, 8'd9, 8'd4};
    xs = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    xt = '{8'd5, 8'd5, 8'd2, 8'd5, 8'd1, 8'd0, 8'd0, 8'd3};
    for (int i = 0; i < 8; i++) begin x0[i] = '0; x2[i] = '0; end
    for (int i = 0; i < 4; i++) x1[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 96'(ov0), 96'(0));
    chk("rst_in_ready", 96'(rdy0), 96'(1));
    chk("rst_y", 96'({so0, pack8(y0)}), 96'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sort, descending then ascending
    send_one(0, xa, 1'b1, cyc);
    chk("lat_desc", 96'(cyc), 96'(6));
    chk("y_desc", 96'({so0, pack8(y0)}), 96'({1'b1, 64'h00010304070909FF}));
`ifdef BITONIC_SORT_IDX_EN
    ei = '{3'd4, 3'd5, 3'd6, 3'd1, 3'd7, 3'd0, 3'd2, 3'd3};
    for (int i = 0; i < 8; i++) chk("idx_desc", 96'(idx0[i]), 96'(ei[i]));
`endif
    @(posedge clk); #1;
    chk("single_out", 96'(ov0), 96'(0));

    send_one(0, xa, 1'b0, cyc);
    chk("lat_asc", 96'(cyc), 96'(6));
    chk("y_asc", 96'({so0, pack8(y0)}), 96'({1'b0, 64'hFF09090704030100}));
`ifdef BITONIC_SORT_IDX_EN
    ei = '{3'd3, 3'd2, 3'd0, 3'd7, 3'd1, 3'd5, 3'd6, 3'd4};
    for (int i = 0; i < 8; i++) chk("idx_asc", 96'(idx0[i]), 96'(ei[i]));
`endif
    @(posedge clk); #1;

    // Back-to-back, alternating directions
    run_stream(8, 100, 0, 0, fc, lc, got);
    chk("b2b_got", 96'(got), 96'(8));
    chk("b2b_first_lat", 96'(fc), 96'(6));
    chk("b2b_span", 96'(lc - fc + 1), 96'(8));
    chk("b2b_sb_empty", 96'(exp_q.size()), 96'(0));
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 5 stalled cycles with input still pending
    run_stream(12, 8, 5, 20, fc, lc, got);
    chk("bp_got", 96'(got), 96'(12));
    chk("bp_first_lat", 96'(fc), 96'(6));
    chk("bp_span", 96'(lc - fc + 1), 96'(17));
    chk("bp_sb_empty", 96'(exp_q.size()), 96'(0));
    repeat (3) @(posedge clk);
    #1;

    // Signed, LOG2_LEN = 2
    send_one(1, xs, 1'b0, cyc);
    chk("sgn_lat", 96'(cyc), 96'(3));
    chk("sgn_asc", 96'({so1, y1[3], y1[2], y1[1], y1[0]}), 96'({1'b0, 32'h7F00FF80}));
`ifdef BITONIC_SORT_IDX_EN
    chk("sgn_idx", 96'({idx1[3], idx1[2], idx1[1], idx1[0]}), 96'({2'd1, 2'd3, 2'd2, 2'd0}));
`endif
    @(posedge clk); #1;
    send_one(1, xs, 1'b1, cyc);
    chk("sgn_desc", 96'({so1, y1[3], y1[2], y1[1], y1[0]}), 96'({1'b1, 32'h80FF007F}));
    @(posedge clk); #1;

    // TOPK = 2
    send_one(2, xt, 1'b1, cyc);
    chk("top_lat", 96'(cyc), 96'(6));
    chk("top_desc", 96'({so2, y2[1], y2[0]}), 96'({1'b1, 16'h0505}));
`ifdef BITONIC_SORT_IDX_EN
    chk("top_idx_desc", 96'({idx2[1], idx2[0]}), 96'({3'd1, 3'd0}));
`endif
    @(posedge clk); #1;
    send_one(2, xt, 1'b0, cyc);
    chk("top_asc", 96'({so2, y2[1], y2[0]}), 96'({1'b0, 16'h0000}));
`ifdef BITONIC_SORT_IDX_EN
    chk("top_idx_asc", 96'({idx2[1], idx2[0]}), 96'({3'd6, 3'd5}));
`endif
    @(posedge clk); #1;

    // Reset mid-flight: three vectors in, first one held at the output
    or0 = 1'b0;
    for (int v = 0; v < 3; v++) begin
      iv0 = 1'b1;
      for (int i = 0; i < 8; i++) x0[i] = vec_val(40 + v, i);
      sc0 = 1'b1;
      @(posedge clk); #1;
    end
    iv0 = 1'b0;
    n = 0;
    while (ov0 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_rst_valid", 96'(ov0), 96'(1));
    chk("pre_rst_ready", 96'(rdy0), 96'(0));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 96'(ov0), 96'(0));
    chk("async_rst_y", 96'({so0, pack8(y0)}), 96'(0));
    chk("async_rst_ready", 96'(rdy0), 96'(1));
`ifdef BITONIC_SORT_IDX_EN
    chk("async_rst_idx", 96'(idx0[0]), 96'(0));
`endif
    @(posedge clk); #2;
    rst = 1'b0;
    or0 = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ov0 === 1'b1) seen++;
    end
    chk("rst_no_leak", 96'(seen), 96'(0));
    send_one(0, xa, 1'b1, cyc);
    chk("post_rst_lat", 96'(cyc), 96'(6));
    chk("post_rst_y", 96'({so0, pack8(y0)}), 96'({1'b1, 64'h00010304070909FF}));
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
